stft_frame_sequencer: RTL and testbench

Sequences sample capture for STFT frame generation. After a start pulse it gates the incoming ADC sample strobe into NUM_FRM windows of WIN_LEN samples, separated by GAP_LEN skipped samples. It emits per-sample window enables, in-window and frame indices, and frame boundary strobes, and gives the FFT/buffer stage its enable and address sequencing. It is built on the team's enable-driven modulo counters, chained through terminal-count enables.

---
 rtl/stft_seq_pkg.sv | 29 ++
 rtl/seq_mod_counter.sv | 44 ++++
 rtl/stft_frame_sequencer.sv | 151 +++++++++++++++
 tb/tb_stft_frame_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stft_seq_pkg.sv
// -----------------------------------------------------------------------------
// stft_seq_pkg
// Shared definitions for the STFT frame sequencer:
//   - seq_state_e : FSM state encodings
//   - cnt_mv      : terminal value of a modulo-n counter (n == 0 -> 0, never hit)
//   - fits_incl / fits_excl : parameter width checks (n <= 2^wl, n < 2^wl)
// -----------------------------------------------------------------------------
package stft_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        GAP     = 2'd2,
        FINISH  = 2'd3
    } seq_state_e;

    function automatic int cnt_mv(input int n);
        return (n > 0) ? n - 1 : 0;
    endfunction

    function automatic bit fits_incl(input int wl, input int n);
        return n <= (1 << wl);
    endfunction

    function automatic bit fits_excl(input int wl, input int n);
        return n < (1 << wl);
    endfunction

endpackage

// File: rtl/seq_mod_counter.sv
// -----------------------------------------------------------------------------
// seq_mod_counter
// Enable-driven modulo counter: counts 0..MV, wraps to 0 after MV.
// Ports:
//   iCLK   clock (rising edge)
//   iRSTn  synchronous active-low reset
//   iCLR   synchronous clear, wins over iEN
//   iEN    advance by one
//   oCNT   current count
//   oTC    terminal count (oCNT == MV), not gated by iEN
// -----------------------------------------------------------------------------
module seq_mod_counter #(
    parameter int WL = 8,
    parameter int MV = 255
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iCLR,
    input  logic          iEN,
    output logic [WL-1:0] oCNT,
    output logic          oTC
);

    localparam logic [WL-1:0] MV_W = WL'(MV);

    logic [WL-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (iCLR)
            cnt_d = '0;
        else if (iEN)
            cnt_d = (cnt_q == MV_W) ? '0 : cnt_q + WL'(1);
    end

    always_ff @(posedge iCLK) begin
        if (!iRSTn) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign oCNT = cnt_q;
    assign oTC  = (cnt_q == MV_W);

endmodule

// File: rtl/stft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// stft_frame_sequencer
// Gates the ADC sample strobe into NUM_FRM windows of WIN_LEN samples separated
// by GAP_LEN skipped samples. Sample, gap and frame counters are chained via
// terminal-count enables; this level holds only the FSM and output decode.
// Ports:
//   iCLK, iRSTn  clock / synchronous active-low reset
//   iSTART       start pulse, only honoured in IDLE
//   iSMP_VLD     ADC sample strobe
//   iABORT       abort in CAPTURE/GAP (only with STFT_SEQ_ABORT_EN)
//   oBUSY        state != IDLE
//   oWIN_EN      current sample is inside a window
//   oSMP_IDX     in-window sample index (registered)
//   oFRM_IDX     window index (registered)
//   oFRM_SOF     first sample of a window
//   oFRM_EOF     last sample of a window
//   oDONE        one-cycle completion pulse
// Optional feature macro: STFT_SEQ_ABORT_EN (adds iABORT).
// -----------------------------------------------------------------------------
module stft_frame_sequencer
    import stft_seq_pkg::*;
#(
    parameter int WIN_WL  = 8,
    parameter int WIN_LEN = 256,
    parameter int GAP_LEN = 0,
    parameter int FRM_WL  = 6,
    parameter int NUM_FRM = 32
) (
    input  logic              iCLK,
    input  logic              iRSTn,
    input  logic              iSTART,
    input  logic              iSMP_VLD,
`ifdef STFT_SEQ_ABORT_EN
    input  logic              iABORT,
`endif
    output logic              oBUSY,
    output logic              oWIN_EN,
    output logic [WIN_WL-1:0] oSMP_IDX,
    output logic [FRM_WL-1:0] oFRM_IDX,
    output logic              oFRM_SOF,
    output logic              oFRM_EOF,
    output logic              oDONE
);

    localparam int SMP_MV = cnt_mv(WIN_LEN);
    localparam int GAP_MV = cnt_mv(GAP_LEN);
    localparam int FRM_MV = cnt_mv(NUM_FRM);

    localparam bit CFG_OK = fits_incl(WIN_WL, WIN_LEN) && fits_excl(WIN_WL, GAP_LEN) &&
                            fits_incl(FRM_WL, NUM_FRM) && (WIN_LEN >= 2) && (NUM_FRM >= 1);

    seq_state_e state_q, state_d;

    logic              smp_en, gap_en, frm_en;
    logic              cnt_clr, frm_clr;
    logic              smp_tc, gap_tc, frm_tc;
    logic [WIN_WL-1:0] smp_cnt, gap_cnt;
    logic [FRM_WL-1:0] frm_cnt;
    logic              abort;

`ifdef STFT_SEQ_ABORT_EN
    assign abort = iABORT;
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge iCLK) begin
        if (!iRSTn) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        smp_en  = 1'b0;
        gap_en  = 1'b0;
        frm_en  = 1'b0;
        cnt_clr = 1'b0;
        frm_clr = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Same-cycle iSMP_VLD is deliberately not captured.
                if (iSTART) begin
                    state_d = CAPTURE;
                    cnt_clr = 1'b1;
                    frm_clr = 1'b1;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                    frm_clr = 1'b1;
                end else if (iSMP_VLD) begin
                    smp_en = 1'b1;     // wraps to 0 by itself at WIN_LEN-1
                    if (smp_tc) begin
                        if (frm_tc) begin
                            state_d = FINISH;   // frame index cleared in FINISH
                        end else begin
                            frm_en = 1'b1;
                            if (GAP_LEN != 0) state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                    frm_clr = 1'b1;
                end else if (iSMP_VLD) begin
                    gap_en = 1'b1;     // wrap on the GAP_LEN-th skip clears it
                    if (gap_tc) state_d = CAPTURE;
                end
            end
            FINISH: begin
                frm_clr = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    seq_mod_counter #(.WL(WIN_WL), .MV(SMP_MV)) u_smp_cnt (
        .iCLK (iCLK), .iRSTn(iRSTn), .iCLR(cnt_clr), .iEN(smp_en),
        .oCNT (smp_cnt), .oTC(smp_tc)
    );

    seq_mod_counter #(.WL(WIN_WL), .MV(GAP_MV)) u_gap_cnt (
        .iCLK (iCLK), .iRSTn(iRSTn), .iCLR(cnt_clr), .iEN(gap_en),
        .oCNT (gap_cnt), .oTC(gap_tc)
    );

    seq_mod_counter #(.WL(FRM_WL), .MV(FRM_MV)) u_frm_cnt (
        .iCLK (iCLK), .iRSTn(iRSTn), .iCLR(frm_clr), .iEN(frm_en),
        .oCNT (frm_cnt), .oTC(frm_tc)
    );

    assign oBUSY    = (state_q != IDLE);
    assign oWIN_EN  = (state_q == CAPTURE) && iSMP_VLD;
    assign oSMP_IDX = smp_cnt;
    assign oFRM_IDX = frm_cnt;
    assign oFRM_SOF = oWIN_EN && (smp_cnt == '0);
    assign oFRM_EOF = oWIN_EN && smp_tc && !abort;
    assign oDONE    = (state_q == FINISH);

    // Parameter sanity and gap-counter idle invariant (simulation only).
    a_cfg: assert property (@(posedge iCLK) CFG_OK);
    a_gap_idle: assert property (@(posedge iCLK) disable iff (!iRSTn)
                                 (state_q != GAP) |-> (gap_cnt == '0));

endmodule

// File: tb/tb_stft_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stft_frame_sequencer
// Directed bench: dut A uses WIN_LEN=4, GAP_LEN=2, NUM_FRM=3; dut B is the
// back-to-back variant (GAP_LEN=0). Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_stft_frame_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic vld = 1'b0;
    logic abort = 1'b0;

    logic       a_busy, a_win, a_sof, a_eof, a_done;
    logic [7:0] a_smp;
    logic [5:0] a_frm;
    logic       b_busy, b_win, b_sof, b_eof, b_done;
    logic [7:0] b_smp;
    logic [5:0] b_frm;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    stft_frame_sequencer #(.WIN_WL(8), .WIN_LEN(4), .GAP_LEN(2), .FRM_WL(6), .NUM_FRM(3)) dut_a (
        .iCLK(clk), .iRSTn(rst_n), .iSTART(start_a), .iSMP_VLD(vld),
`ifdef STFT_SEQ_ABORT_EN
        .iABORT(abort),
`endif
        .oBUSY(a_busy), .oWIN_EN(a_win), .oSMP_IDX(a_smp), .oFRM_IDX(a_frm),
        .oFRM_SOF(a_sof), .oFRM_EOF(a_eof), .oDONE(a_done)
    );

    stft_frame_sequencer #(.WIN_WL(8), .WIN_LEN(4), .GAP_LEN(0), .FRM_WL(6), .NUM_FRM(3)) dut_b (
        .iCLK(clk), .iRSTn(rst_n), .iSTART(start_b), .iSMP_VLD(vld),
`ifdef STFT_SEQ_ABORT_EN
        .iABORT(1'b0),
`endif
        .oBUSY(b_busy), .oWIN_EN(b_win), .oSMP_IDX(b_smp), .oFRM_IDX(b_frm),
        .oFRM_SOF(b_sof), .oFRM_EOF(b_eof), .oDONE(b_done)
    );

    // {win, sof, eof, smp_idx, frm_idx}
    logic [16:0] a_vec, b_vec;
    assign a_vec = {a_win, a_sof, a_eof, a_smp, a_frm};
    assign b_vec = {b_win, b_sof, b_eof, b_smp, b_frm};

    // Hand-computed nominal sequence, one entry per valid sample after start.
    int exp_smp[16] = '{0,1,2,3, 0,0, 0,1,2,3, 0,0, 0,1,2,3};
    int exp_frm[16] = '{0,0,0,0, 1,1, 1,1,1,1, 2,2, 2,2,2,2};
    bit exp_win[16] = '{1,1,1,1, 0,0, 1,1,1,1, 0,0, 1,1,1,1};
    bit exp_sof[16] = '{1,0,0,0, 0,0, 1,0,0,0, 0,0, 1,0,0,0};
    bit exp_eof[16] = '{0,0,0,1, 0,0, 0,0,0,1, 0,0, 0,0,0,1};

    function automatic logic [16:0] nom_exp(input int k);
        return {exp_win[k], exp_sof[k], exp_eof[k], 8'(exp_smp[k]), 6'(exp_frm[k])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full nominal run on dut A with a continuous strobe.
    task automatic run_full_a(input string tag);
        start_a = 1'b1;
        vld = 1'b0;
        tick();
        start_a = 1'b0;
        vld = 1'b1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            vecs++;
            if (a_vec !== nom_exp(k) || a_busy !== 1'b1 || a_done !== 1'b0) begin
                errs++;
                $display("FAIL %s sample %0d: got vec=%h busy=%b done=%b want vec=%h busy=1 done=0",
                         tag, k, a_vec, a_busy, a_done, nom_exp(k));
            end
            tick();
        end
        @(negedge clk);
        vecs++;
        if (a_done !== 1'b1 || a_busy !== 1'b1 || a_win !== 1'b0) begin
            errs++;
            $display("FAIL %s done_pulse: got done=%b busy=%b win=%b want 1 1 0", tag, a_done, a_busy, a_win);
        end
        tick();
        @(negedge clk);
        vecs++;
        if (a_done !== 1'b0 || a_busy !== 1'b0 || a_frm !== 6'd0 || a_win !== 1'b0) begin
            errs++;
            $display("FAIL %s after_done: got done=%b busy=%b frm=%0d win=%b want 0 0 0 0",
                     tag, a_done, a_busy, a_frm, a_win);
        end
        vld = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        vld = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        @(negedge clk);
        vecs++;
        if ({a_busy, a_win, a_smp, a_frm, a_sof, a_eof, a_done} !== '0) begin
            errs++;
            $display("FAIL reset_state: got busy=%b win=%b smp=%0d frm=%0d sof=%b eof=%b done=%b want all 0",
                     a_busy, a_win, a_smp, a_frm, a_sof, a_eof, a_done);
        end
        rst_n = 1'b1;
        vld = 1'b0;
        tick();
        // Reset mid-window at sample index 2.
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        vld = 1'b1;
        tick();
        tick();
        @(negedge clk);
        vecs++;
        if (a_smp !== 8'd2 || a_win !== 1'b1) begin
            errs++;
            $display("FAIL reset_setup: got smp=%0d win=%b want 2 1", a_smp, a_win);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        vecs++;
        if ({a_busy, a_win, a_smp, a_frm, a_sof, a_eof, a_done} !== '0) begin
            errs++;
            $display("FAIL reset_mid_capture: got busy=%b win=%b smp=%0d frm=%0d sof=%b eof=%b done=%b want all 0",
                     a_busy, a_win, a_smp, a_frm, a_sof, a_eof, a_done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            vecs++;
            if (a_done !== 1'b0 || a_busy !== 1'b0) begin
                errs++;
                $display("FAIL reset_no_done: got done=%b busy=%b want 0 0", a_done, a_busy);
            end
        end
        vld = 1'b0;
        tick();
    endtask

    task automatic test_nominal();
        run_full_a("nominal");
    endtask

    task automatic test_sparse();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            vld = 1'b1;
            @(negedge clk);
            vecs++;
            if (a_vec !== nom_exp(k)) begin
                errs++;
                $display("FAIL sparse sample %0d: got %h want %h", k, a_vec, nom_exp(k));
            end
            tick();
            vld = 1'b0;
            for (int j = 0; j < 2; j++) begin
                @(negedge clk);
                vecs++;
                if (k < 15) begin
                    if (a_win !== 1'b0 || a_smp !== 8'(exp_smp[k+1]) || a_frm !== 6'(exp_frm[k+1])) begin
                        errs++;
                        $display("FAIL sparse hold %0d.%0d: got win=%b smp=%0d frm=%0d want 0 %0d %0d",
                                 k, j, a_win, a_smp, a_frm, exp_smp[k+1], exp_frm[k+1]);
                    end
                end else if (j == 0) begin
                    if (a_done !== 1'b1 || a_busy !== 1'b1) begin
                        errs++;
                        $display("FAIL sparse done: got done=%b busy=%b want 1 1", a_done, a_busy);
                    end
                end else begin
                    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
                        errs++;
                        $display("FAIL sparse idle: got done=%b busy=%b want 0 0", a_done, a_busy);
                    end
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [16:0] e;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        vld = 1'b1;
        for (int k = 0; k < 12; k++) begin
            e = {1'b1, (k % 4) == 0, (k % 4) == 3, 8'(k % 4), 6'(k / 4)};
            @(negedge clk);
            vecs++;
            if (b_vec !== e || b_done !== 1'b0) begin
                errs++;
                $display("FAIL b2b sample %0d: got vec=%h done=%b want vec=%h done=0", k, b_vec, b_done, e);
            end
            tick();
        end
        @(negedge clk);
        vecs++;
        if (b_done !== 1'b1 || b_win !== 1'b0) begin
            errs++;
            $display("FAIL b2b done: got done=%b win=%b want 1 0", b_done, b_win);
        end
        tick();
        vld = 1'b0;
        @(negedge clk);
        vecs++;
        if (b_done !== 1'b0 || b_busy !== 1'b0) begin
            errs++;
            $display("FAIL b2b idle: got done=%b busy=%b want 0 0", b_done, b_busy);
        end
        tick();
    endtask

    task automatic test_start_rules();
        start_a = 1'b1;
        vld = 1'b1;
        @(negedge clk);
        vecs++;
        if (a_win !== 1'b0 || a_busy !== 1'b0 || a_sof !== 1'b0) begin
            errs++;
            $display("FAIL start_same_cycle: got win=%b busy=%b sof=%b want 0 0 0", a_win, a_busy, a_sof);
        end
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (k == 1) start_a = 1'b1;
            @(negedge clk);
            vecs++;
            if (a_vec !== nom_exp(k)) begin
                errs++;
                $display("FAIL start_rules sample %0d: got %h want %h", k, a_vec, nom_exp(k));
            end
            tick();
            start_a = 1'b0;
        end
        @(negedge clk);
        vecs++;
        if (a_done !== 1'b1) begin
            errs++;
            $display("FAIL start_rules done: got %b want 1", a_done);
        end
        tick();
        vld = 1'b0;
        tick();
    endtask

`ifdef STFT_SEQ_ABORT_EN
    task automatic test_abort();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        vld = 1'b1;
        for (int k = 0; k < 7; k++) tick();
        abort = 1'b1;
        @(negedge clk);
        vecs++;
        if (a_smp !== 8'd1 || a_frm !== 6'd1 || a_eof !== 1'b0) begin
            errs++;
            $display("FAIL abort_cycle: got smp=%0d frm=%0d eof=%b want 1 1 0", a_smp, a_frm, a_eof);
        end
        tick();
        abort = 1'b0;
        vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vecs++;
            if (a_busy !== 1'b0 || a_smp !== 8'd0 || a_frm !== 6'd0 || a_done !== 1'b0) begin
                errs++;
                $display("FAIL abort_idle %0d: got busy=%b smp=%0d frm=%0d done=%b want 0 0 0 0",
                         i, a_busy, a_smp, a_frm, a_done);
            end
            tick();
        end
        run_full_a("abort_rerun");
    endtask
`endif

    initial begin
        test_reset();
        test_nominal();
        test_sparse();
        test_back_to_back();
        test_start_rules();
`ifdef STFT_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
